sram_rec_play_ctrl: RTL

- Sequential initiator for the SRAM codec bridge in the audio record/playback path.
- Record mode: accepts 16-bit samples and writes them to consecutive SRAM addresses.
- Play mode: reads samples back in the same order on request.
- Drives the bridge's write/read/on/address/data-in lines and captures its read data. Holds every access stable for a fixed number of cycles.

---
 rtl/sram_rec_play_ctrl.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/sram_rec_play_ctrl.sv
// sram_rec_play_ctrl
//   Sequential initiator for the SRAM codec bridge. Record mode writes incoming
//   16-bit samples to consecutive word addresses starting at 0. Play mode reads
//   them back in the same order, one read per sample_req. Each SRAM access holds
//   its strobe for ACCESS_CYCLES cycles.
//
//   Optional feature (macro SRAM_LOOP_PLAY_EN): playback wraps to address 0 at
//   the end of the recording instead of stopping. It then ends only on i_stop.
//
// Ports
//   clk, rst          : clock (rising edge), asynchronous active-high reset
//   i_record, i_play  : level starts for record / playback (record wins)
//   i_stop            : pulse, ends the current mode (deferred during an access)
//   sample_in[_valid] : sample to record and its one-cycle qualifier
//   sample_req        : one-cycle request for the next playback sample
//   sample_out[_valid]: playback sample and its one-cycle qualifier
//   sram_write/read/on, sram_addr, sram_wdata, sram_rdata : bridge interface
//   rec_len           : number of samples stored by the last recording
//   busy              : controller not idle
//   done              : one-cycle pulse when record or playback ends
//   overrun           : sticky, a sample arrived while a write was in progress
module sram_rec_play_ctrl #(
  parameter int unsigned       ADDR_W        = 18,
  parameter logic [ADDR_W-1:0] MAX_ADDR      = 18'h3FFFF,
  parameter int unsigned       ACCESS_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_record,
  input  logic              i_play,
  input  logic              i_stop,
  input  logic [15:0]       sample_in,
  input  logic              sample_in_valid,
  input  logic              sample_req,
  output logic [15:0]       sample_out,
  output logic              sample_out_valid,
  output logic              sram_write,
  output logic              sram_read,
  output logic              sram_on,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_wdata,
  input  logic [15:0]       sram_rdata,
  output logic [ADDR_W:0]   rec_len,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  typedef enum logic [2:0] {
    IDLE,
    REC_WAIT,
    REC_WR,
    PLAY_WAIT,
    PLAY_RD
  } state_t;

  localparam logic [3:0]    LAST_CNT = 4'(ACCESS_CYCLES - 1);
  localparam logic [ADDR_W:0] ONE    = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_q, state_d;
  // Pointers are one bit wider than the address so that MAX_ADDR+1 fits.
  logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   rec_len_q, rec_len_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              stop_pend_q, stop_pend_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic [15:0]       sout_q, sout_d;
  logic              sout_valid_q, sout_valid_d;
  logic              done_q, done_d;
  logic              overrun_q, overrun_d;
  logic              access_last;
  logic [ADDR_W:0]   rd_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      rec_len_q    <= '0;
      cnt_q        <= '0;
      stop_pend_q  <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      sout_q       <= '0;
      sout_valid_q <= 1'b0;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rec_len_q    <= rec_len_d;
      cnt_q        <= cnt_d;
      stop_pend_q  <= stop_pend_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      sout_q       <= sout_d;
      sout_valid_q <= sout_valid_d;
      done_q       <= done_d;
      overrun_q    <= overrun_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    rec_len_d    = rec_len_q;
    cnt_d        = '0;
    stop_pend_d  = stop_pend_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    sout_d       = sout_q;
    sout_valid_d = 1'b0;
    done_d       = 1'b0;
    overrun_d    = overrun_q;
    access_last  = (cnt_q == LAST_CNT);
    rd_next      = rd_ptr_q + ONE;

    case (state_q)
      IDLE: begin
        stop_pend_d = 1'b0;
        if (i_record) begin
          state_d   = REC_WAIT;
          wr_ptr_d  = '0;
          overrun_d = 1'b0;
        end else if (i_play) begin
          if (rec_len_q != '0) begin
            state_d  = PLAY_WAIT;
            rd_ptr_d = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      REC_WAIT: begin
        // A stop arriving with a sample still records that sample first.
        if (sample_in_valid) begin
          wdata_d     = sample_in;
          addr_d      = wr_ptr_q[ADDR_W-1:0];
          state_d     = REC_WR;
          stop_pend_d = i_stop;
        end else if (i_stop) begin
          state_d   = IDLE;
          rec_len_d = wr_ptr_q;
          done_d    = 1'b1;
        end
      end

      REC_WR: begin
        if (sample_in_valid) begin
          overrun_d = 1'b1;
        end
        if (access_last) begin
          wr_ptr_d = wr_ptr_q + ONE;
          if (addr_q == MAX_ADDR || stop_pend_q || i_stop) begin
            state_d     = IDLE;
            rec_len_d   = wr_ptr_q + ONE;
            done_d      = 1'b1;
            stop_pend_d = 1'b0;
          end else begin
            state_d = REC_WAIT;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (i_stop) begin
            stop_pend_d = 1'b1;
          end
        end
      end

      PLAY_WAIT: begin
        if (sample_req) begin
          addr_d      = rd_ptr_q[ADDR_W-1:0];
          state_d     = PLAY_RD;
          stop_pend_d = i_stop;
        end else if (i_stop) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end

      PLAY_RD: begin
        if (access_last) begin
          // Sample and done become visible together in the following cycle.
          sout_d       = sram_rdata;
          sout_valid_d = 1'b1;
          rd_ptr_d     = rd_next;
          if (stop_pend_q || i_stop) begin
            state_d     = IDLE;
            done_d      = 1'b1;
            stop_pend_d = 1'b0;
          end else if (rd_next == rec_len_q) begin
`ifdef SRAM_LOOP_PLAY_EN
            rd_ptr_d = '0;
            state_d  = PLAY_WAIT;
`else
            state_d = IDLE;
            done_d  = 1'b1;
`endif
          end else begin
            state_d = PLAY_WAIT;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (i_stop) begin
            stop_pend_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Strobes decode directly from the state register so an async reset drops
  // them in the same instant.
  assign sram_write       = (state_q == REC_WR);
  assign sram_read        = (state_q == PLAY_RD);
  assign sram_on          = (state_q != IDLE);
  assign busy             = (state_q != IDLE);
  assign sram_addr        = addr_q;
  assign sram_wdata       = wdata_q;
  assign sample_out       = sout_q;
  assign sample_out_valid = sout_valid_q;
  assign rec_len          = rec_len_q;
  assign done             = done_q;
  assign overrun          = overrun_q;

endmodule
